bin_to_ascii_dec_seq: RTL and testbench

- Parametrised, sequential binary-to-ASCII decimal formatter for the VGA text overlay (timer/counter readouts).
- Converts an IN_WIDTH-bit value, optionally signed, with an iterative double-dabble engine, one bit per clock.
- Produces a packed, MSB-first character field with configurable digit count, leading blank/zero, trailing padding and overflow marking.
- Start/busy/done handshake; the output is registered and held between conversions.

---
 rtl/text_pkg.sv | 23 ++
 rtl/dabble_digit.sv | 9 +
 rtl/bin_to_ascii_dec_seq.sv | 135 +++++++++++++
 tb/tb_bin_to_ascii_dec_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared character constants, BCD sizing helper and FSM encoding for the
// text-overlay number formatters.
package text_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_HASH  = 8'h23;

  localparam int CHAR_W_DEF = 7;

  // Each BCD nibble absorbs at most ~3.32 binary bits, so width/3+1 never loses data.
  function automatic int bcd_nibbles(input int width);
    return width / 3 + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_FORMAT
  } fmt_state_t;

endpackage

// File: rtl/dabble_digit.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more.
module dabble_digit (
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  assign corrected = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin_to_ascii_dec_seq.sv
// Sequential binary-to-decimal ASCII formatter: one double-dabble bit per clock,
// then a single formatting cycle builds the MSB-first character field.
module bin_to_ascii_dec_seq
  import text_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int DIGITS    = 6,
  parameter int PAD_CHARS = 1,
  parameter int LEAD_ZERO = 0,
  parameter int SIGNED    = 0,
  parameter int CHAR_W    = CHAR_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [IN_WIDTH-1:0]                  input_val,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow,
  output logic [(DIGITS+PAD_CHARS)*CHAR_W-1:0] packed_val
);

  localparam int NIB     = bcd_nibbles(IN_WIDTH);
  localparam int FN      = (NIB > DIGITS) ? NIB : DIGITS;
  localparam int CNT_W   = $clog2(IN_WIDTH + 1);
  localparam int TOTAL_W = (DIGITS + PAD_CHARS) * CHAR_W;
  localparam logic [TOTAL_W-1:0] SPACES = {(DIGITS + PAD_CHARS){CHAR_W'(ASCII_SPACE)}};

  fmt_state_t          state_reg;
  logic [IN_WIDTH:0]   mag_reg;
  logic [4*NIB-1:0]    bcd_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                neg_reg;
  logic                spill_reg;

  logic [IN_WIDTH-1:0] mag_in;
  logic                neg_in;
  logic [4*NIB-1:0]    bcd_corr;
  logic [4*NIB:0]      bcd_shift;
  logic [4*FN-1:0]     bcd_ext;
  logic [TOTAL_W-1:0]  fmt_val;
  logic                fmt_ovf;
  logic [CHAR_W-1:0]   ch;
  int                  msd;

  // Unsigned negate of a W-bit two's-complement value is exact, including the most-negative one.
  assign neg_in = (SIGNED != 0) && input_val[IN_WIDTH-1];
  assign mag_in = neg_in ? -input_val : input_val;

  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_dabble
      dabble_digit u_digit (
        .nibble    (bcd_reg[4*gi +: 4]),
        .corrected (bcd_corr[4*gi +: 4])
      );
    end
  endgenerate

  // The magnitude sits left-aligned in mag_reg so its top bit feeds the BCD shift.
  assign bcd_shift = {bcd_corr, mag_reg[IN_WIDTH]};
  assign bcd_ext   = (4*FN)'(bcd_reg);

  always_comb begin
    msd = 0;
    for (int p = 0; p < NIB; p++)
      if (bcd_reg[4*p +: 4] != 4'd0) msd = p;

    fmt_ovf = spill_reg;
    for (int p = DIGITS; p < NIB; p++)
      if (bcd_reg[4*p +: 4] != 4'd0) fmt_ovf = 1'b1;
    if (neg_reg && (msd + 1 > DIGITS - 1)) fmt_ovf = 1'b1;

    fmt_val = SPACES;
    ch      = CHAR_W'(ASCII_SPACE);
    for (int p = 0; p < DIGITS; p++) begin
      if (fmt_ovf)
        ch = CHAR_W'(ASCII_HASH);
      else if (p <= msd)
        ch = CHAR_W'(ASCII_ZERO + {4'd0, bcd_ext[4*p +: 4]});
      else if (neg_reg && (LEAD_ZERO != 0) && (p == DIGITS - 1))
        ch = CHAR_W'(ASCII_MINUS);
      else if (neg_reg && (LEAD_ZERO == 0) && (p == msd + 1))
        ch = CHAR_W'(ASCII_MINUS);
      else
        ch = (LEAD_ZERO != 0) ? CHAR_W'(ASCII_ZERO) : CHAR_W'(ASCII_SPACE);
      fmt_val[(PAD_CHARS + p)*CHAR_W +: CHAR_W] = ch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      mag_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      spill_reg  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      packed_val <= SPACES;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mag_reg   <= {mag_in, 1'b0};
            neg_reg   <= neg_in;
            bcd_reg   <= '0;
            spill_reg <= 1'b0;
            cnt_reg   <= CNT_W'(IN_WIDTH);
            busy      <= 1'b1;
            state_reg <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          bcd_reg   <= bcd_shift[4*NIB-1:0];
          spill_reg <= spill_reg | bcd_shift[4*NIB];
          mag_reg   <= {mag_reg[IN_WIDTH-1:0], 1'b0};
          cnt_reg   <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_reg <= ST_FORMAT;
        end
        ST_FORMAT: begin
          packed_val <= fmt_val;
          overflow   <= fmt_ovf;
          done       <= 1'b1;
          busy       <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_ascii_dec_seq.sv
// Drives four formatter configurations in lockstep from one stimulus stream and
// checks each against an arithmetic decimal-formatting model.
module tb_bin_to_ascii_dec_seq;

  localparam int CW = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] input_val = '0;

  logic busy_a, done_a, ovf_a;
  logic busy_b, done_b, ovf_b;
  logic busy_c, done_c, ovf_c;
  logic busy_d, done_d, ovf_d;
  logic [7*CW-1:0] pv_a;
  logic [5*CW-1:0] pv_b;
  logic [7*CW-1:0] pv_c;
  logic [7*CW-1:0] pv_d;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bin_to_ascii_dec_seq u_def (
    .clk(clk), .reset(reset), .start(start), .input_val(input_val),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .packed_val(pv_a));

  bin_to_ascii_dec_seq #(.DIGITS(4)) u_d4 (
    .clk(clk), .reset(reset), .start(start), .input_val(input_val),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .packed_val(pv_b));

  bin_to_ascii_dec_seq #(.SIGNED(1)) u_sg (
    .clk(clk), .reset(reset), .start(start), .input_val(input_val),
    .busy(busy_c), .done(done_c), .overflow(ovf_c), .packed_val(pv_c));

  bin_to_ascii_dec_seq #(.SIGNED(1), .LEAD_ZERO(1)) u_sz (
    .clk(clk), .reset(reset), .start(start), .input_val(input_val),
    .busy(busy_d), .done(done_d), .overflow(ovf_d), .packed_val(pv_d));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decimal rendering from plain arithmetic; one trailing pad space, chars right-aligned.
  function automatic logic [127:0] model(input logic [15:0] v, input int digits,
                                         input bit lz, input bit sgn, output bit ovf);
    longint m, p10;
    bit neg;
    int nd;
    logic [7:0] ch;
    logic [127:0] r;
    neg = sgn && v[15];
    m = neg ? 65536 - longint'(v) : longint'(v);
    nd = 1;
    for (longint t = m; t >= 10; t = t / 10) nd++;
    ovf = (nd > digits) || (neg && nd > digits - 1);
    r = '0;
    r[CW-1:0] = 7'h20;
    p10 = 1;
    for (int p = 0; p < digits; p++) begin
      if (ovf) ch = "#";
      else if (p < nd) ch = 8'h30 + 8'((m / p10) % 10);
      else if (neg && lz && p == digits - 1) ch = "-";
      else if (neg && !lz && p == nd) ch = "-";
      else ch = lz ? "0" : " ";
      r[(p + 1)*CW +: CW] = ch[CW-1:0];
      p10 = p10 * 10;
    end
    return r;
  endfunction

  task automatic check_outputs(input logic [15:0] v, input string tag);
    logic [127:0] e;
    bit o;
    e = model(v, 6, 0, 0, o);
    chk({tag, "/def_val"}, pv_a, e);  chk({tag, "/def_ovf"}, ovf_a, o);
    e = model(v, 4, 0, 0, o);
    chk({tag, "/d4_val"}, pv_b, e);   chk({tag, "/d4_ovf"}, ovf_b, o);
    e = model(v, 6, 0, 1, o);
    chk({tag, "/sgn_val"}, pv_c, e);  chk({tag, "/sgn_ovf"}, ovf_c, o);
    e = model(v, 6, 1, 1, o);
    chk({tag, "/sgnlz_val"}, pv_d, e); chk({tag, "/sgnlz_ovf"}, ovf_d, o);
    $display("conv %s in=%h def=%h d4=%h sgn=%h sgnlz=%h", tag, v, pv_a, pv_b, pv_c, pv_d);
  endtask

  // Called with time #1 after an edge where the DUTs are idle; start is accepted at the next edge.
  task automatic convert(input logic [15:0] v, input bit hold, input bit b2b_next, input string tag);
    int k;
    bit busy_ok;
    input_val = v;
    start = 1'b1;
    @(posedge clk); #1;
    if (hold) input_val = 16'd1;
    else start = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    while (!done_a && k < 40) begin
      if (!(busy_a && busy_b && busy_c && busy_d)) busy_ok = 1'b0;
      if (done_b || done_c || done_d) busy_ok = 1'b0;
      if (hold && k >= 17) start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk({tag, "/done_cycle"}, k, 18);
    chk({tag, "/busy_during"}, busy_ok, 1'b1);
    chk({tag, "/done_all"}, {done_a, done_b, done_c, done_d}, 4'hF);
    chk({tag, "/busy_at_done"}, {busy_a, busy_b, busy_c, busy_d}, 4'h0);
    check_outputs(v, tag);
    if (!b2b_next) begin
      @(posedge clk); #1;
      chk({tag, "/done_pulse"}, {done_a, done_b, done_c, done_d}, 4'h0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [7*CW-1:0] sp7;
    logic [5*CW-1:0] sp5;
    sp7 = {7{7'h20}};
    sp5 = {5{7'h20}};
    chk({tag, "/busy"}, {busy_a, busy_b, busy_c, busy_d}, 4'h0);
    chk({tag, "/done"}, {done_a, done_b, done_c, done_d}, 4'h0);
    chk({tag, "/ovf"}, {ovf_a, ovf_b, ovf_c, ovf_d}, 4'h0);
    chk({tag, "/def_val"}, pv_a, sp7);
    chk({tag, "/d4_val"}, pv_b, sp5);
    chk({tag, "/sgn_val"}, pv_c, sp7);
    chk({tag, "/sgnlz_val"}, pv_d, sp7);
    $display("reset %s def=%h d4=%h", tag, pv_a, pv_b);
  endtask

  initial begin : stim
    bit stray_done;
    logic [15:0] rv;

    // Reset with start asserted: reset must win.
    start = 1'b1;
    input_val = 16'd77;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    start = 1'b0;
    reset = 1'b0;

    convert(16'd0, 0, 0, "zero");
    convert(16'd65535, 0, 0, "max");
    convert(16'd65535, 1, 0, "held_start");
    convert(16'd12345, 0, 0, "v12345");

    // Abort mid-conversion at cycle 9, after a result that left overflow set on the 4-digit unit.
    input_val = 16'd123;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("abort");
    reset = 1'b0;
    stray_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_a || done_b || done_c || done_d || busy_a) stray_done = 1'b1;
    end
    chk("abort/no_done", stray_done, 1'b0);

    convert(16'd9999, 0, 0, "v9999");
    convert(16'h8000, 0, 0, "most_neg");
    convert(16'hFFFF, 0, 0, "minus_one");
    convert(16'hFFD6, 0, 0, "minus_42");
    convert(16'd42, 0, 1, "b2b_42");
    convert(16'd7, 0, 0, "b2b_7");

    for (int i = 0; i < 40; i++) begin
      rv = 16'($urandom_range(0, 65535));
      convert(rv, 0, 0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
